// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, ALU selects, skip conditions
// and the controller's FSM state encodings.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_HALT  = 4'd1,
        OP_LOAD  = 4'd2,
        OP_STORE = 4'd3,
        OP_CLEAR = 4'd4,
        OP_SKIP  = 4'd5,
        OP_JUMP  = 4'd6,
        OP_SUB   = 4'd7,
        OP_AND   = 4'd8,
        OP_OR    = 4'd9,
        OP_NOT   = 4'd10
    } opcode_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b100;

    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_F_ADDR = 4'd1;
    localparam logic [3:0] S_F_READ = 4'd2;
    localparam logic [3:0] S_DECODE = 4'd3;
    localparam logic [3:0] S_M_ADDR = 4'd4;
    localparam logic [3:0] S_M_READ = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_WB     = 4'd7;
    localparam logic [3:0] S_STORE  = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    function automatic logic [2:0] alu_sel_for(input opcode_e op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/cpu_skip_eval.sv
// SKIP condition evaluator: decides from AC and the two condition bits whether the
// next instruction is skipped.
module cpu_skip_eval
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_ac,
    input  logic [1:0]            i_cond,
    output logic                  o_take
);

    logic w_neg;
    logic w_zero;

    assign w_neg  = i_ac[DATA_WIDTH-1];
    assign w_zero = (i_ac == '0);

    always_comb begin
        case (i_cond)
            SKIP_NEG:  o_take = w_neg;
            SKIP_ZERO: o_take = w_zero;
            SKIP_POS:  o_take = !w_neg && !w_zero;
            default:   o_take = 1'b0;
        endcase
    end

endmodule

// File: rtl/accum_cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU. Owns PC, IR,
// MBR and AC and drives the external single-port RAM and combinational ALU.
module accum_cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h100,
    parameter int unsigned PC_STEP    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_cs,
    output logic                  o_mem_we,
    output logic                  o_mem_oe,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [31:0]           o_alu_a,
    output logic [31:0]           o_alu_b,
    output logic [2:0]            o_alu_sel,
    input  logic [31:0]           i_alu_out,
    output logic [31:0]           o_pc,
    output logic [DATA_WIDTH-1:0] o_ac,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic                  o_instr_done,
    output logic                  o_halted
);

    logic [3:0]            r_state;
    logic [3:0]            w_state_d;
    logic [31:0]           r_pc;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] r_mbr;
    logic [DATA_WIDTH-1:0] r_ac;

    opcode_e               w_opcode;
    logic [ADDR_WIDTH-1:0] w_operand;
    logic [31:0]           w_pc_inc;
    logic                  w_take;
    logic                  w_decode_done;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_cs;
    logic                  w_oe;
    logic                  w_we;

    assign w_opcode      = opcode_e'(r_ir[30:27]);
    assign w_operand     = r_ir[ADDR_WIDTH-1:0];
    assign w_pc_inc      = r_pc + 32'(PC_STEP);
    assign w_decode_done = !(w_opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                                              OP_LOAD, OP_STORE, OP_HALT});

    cpu_skip_eval #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skip_eval (
        .i_ac   (r_ac),
        .i_cond (r_ir[11:10]),
        .o_take (w_take)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_d = S_F_ADDR;
            S_F_ADDR: w_state_d = S_F_READ;
            S_F_READ: w_state_d = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: w_state_d = S_M_ADDR;
                    OP_STORE: w_state_d = S_STORE;
                    OP_HALT:  w_state_d = S_HALT;
                    default:  w_state_d = S_F_ADDR;
                endcase
            end
            S_M_ADDR: w_state_d = S_M_READ;
            S_M_READ: w_state_d = (w_opcode == OP_LOAD) ? S_WB : S_EXEC;
            S_EXEC:   w_state_d = S_WB;
            S_WB:     w_state_d = S_F_ADDR;
            S_STORE:  w_state_d = S_F_ADDR;
            S_HALT:   w_state_d = S_HALT;
            default:  w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_mbr   <= '0;
            r_ac    <= '0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                S_F_READ: begin
                    r_ir <= i_mem_rdata;
                    r_pc <= w_pc_inc;
                end
                S_DECODE: begin
                    case (w_opcode)
                        OP_CLEAR: r_ac <= '0;
                        OP_NOT:   r_ac <= ~r_ac;
                        OP_JUMP:  r_pc <= {5'd0, r_ir[26:0]};
                        OP_SKIP:  if (w_take) r_pc <= w_pc_inc;
                        default:  ;
                    endcase
                end
                S_M_READ: r_mbr <= i_mem_rdata;
                S_WB:     r_ac  <= (w_opcode == OP_LOAD) ? r_mbr : i_alu_out;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_addr       = '0;
        w_cs         = 1'b0;
        w_oe         = 1'b0;
        w_we         = 1'b0;
        o_alu_sel    = ALU_AND;
        o_instr_done = 1'b0;
        o_halted     = 1'b0;
        case (r_state)
            S_F_ADDR, S_F_READ: begin
                w_addr = r_pc[ADDR_WIDTH-1:0];
                w_cs   = 1'b1;
                w_oe   = 1'b1;
            end
            S_M_ADDR, S_M_READ: begin
                w_addr = w_operand;
                w_cs   = 1'b1;
                w_oe   = 1'b1;
            end
            S_STORE: begin
                w_addr       = w_operand;
                w_cs         = 1'b1;
                w_we         = 1'b1;
                o_instr_done = 1'b1;
            end
            S_DECODE: o_instr_done = w_decode_done;
            S_EXEC:   o_alu_sel = alu_sel_for(w_opcode);
            S_WB: begin
                o_alu_sel    = alu_sel_for(w_opcode);
                o_instr_done = 1'b1;
            end
            S_HALT:   o_halted = 1'b1;
            default:  ;
        endcase
    end

    // Strobes are masked while reset is high so an interrupted STORE never writes.
    assign o_mem_addr  = w_addr;
    assign o_mem_cs    = w_cs & ~i_reset;
    assign o_mem_oe    = w_oe & ~i_reset;
    assign o_mem_we    = w_we & ~i_reset;
    assign o_mem_wdata = r_ac;
    assign o_alu_a     = r_ac;
    assign o_alu_b     = r_mbr;
    assign o_pc        = r_pc;
    assign o_ac        = r_ac;
    assign o_ir        = r_ir;

endmodule

// File: tb/tb_accum_cpu_controller.sv
// Bench for accum_cpu_controller: RAM and ALU environment, ISA-level reference model
// with a per-instruction latency table, directed programs and random programs.
module tb_accum_cpu_controller;

    localparam int unsigned AW        = 14;
    localparam int unsigned MEM_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic          mem_cs, mem_we, mem_oe;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [31:0]   alu_a, alu_b, alu_out;
    logic [2:0]    alu_sel;
    logic [31:0]   pc, ac, ir;
    logic          done, halted;

    logic [31:0]   ram [MEM_WORDS];
    logic [31:0]   mm  [MEM_WORDS];
    logic          load_req;

    int vectors;
    int miscompares;

    logic [31:0] m_pc, m_ac;
    bit          m_halt;
    logic [31:0] trace_pc[$], trace_ac[$], st_q[$], st_addr_q[$], sel_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    accum_cpu_controller dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .o_mem_addr   (mem_addr),
        .o_mem_cs     (mem_cs),
        .o_mem_we     (mem_we),
        .o_mem_oe     (mem_oe),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_sel    (alu_sel),
        .i_alu_out    (alu_out),
        .o_pc         (pc),
        .o_ac         (ac),
        .o_ir         (ir),
        .o_instr_done (done),
        .o_halted     (halted)
    );

    always_comb begin
        case (alu_sel)
            3'b001:  alu_out = alu_a + alu_b;
            3'b010:  alu_out = alu_a - alu_b;
            3'b100:  alu_out = alu_a | alu_b;
            default: alu_out = alu_a & alu_b;
        endcase
    end

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < MEM_WORDS; i++) ram[i] <= mm[i];
        end else begin
            if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr];
            if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [26:0] a);
        return {1'b0, op, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEM_WORDS; i++) mm[i] = 32'd0;
    endtask

    task automatic load_mem();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
        tick();
        chk("rst_pc", pc, 32'h100);
        chk("rst_ac", ac, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_flags", {27'd0, alu_sel, done, halted}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        m_pc = 32'h100;
        m_ac = 32'd0;
        trace_pc.delete(); trace_ac.delete(); st_q.delete();
        st_addr_q.delete(); sel_q.delete(); lat_q.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Executes one instruction in the model and checks the DUT cycle by cycle.
    task automatic step_instr(input bit noise);
        logic [31:0]   w, opnd_val, npc, nac, exp_sel;
        logic [3:0]    op;
        logic [AW-1:0] opa;
        int            lat, obs, wcnt;
        bit            is_alu, take;
        w        = mm[m_pc[AW-1:0]];
        op       = w[30:27];
        opa      = w[AW-1:0];
        opnd_val = mm[opa];
        npc      = m_pc + 32'd2;
        nac      = m_ac;
        lat      = 3;
        is_alu   = 1'b0;
        take     = 1'b0;
        exp_sel  = 32'd0;
        case (op)
            4'd0:  begin lat = 7; is_alu = 1'b1; nac = m_ac + opnd_val; exp_sel = 32'd1; end
            4'd7:  begin lat = 7; is_alu = 1'b1; nac = m_ac - opnd_val; exp_sel = 32'd2; end
            4'd8:  begin lat = 7; is_alu = 1'b1; nac = m_ac & opnd_val; exp_sel = 32'd0; end
            4'd9:  begin lat = 7; is_alu = 1'b1; nac = m_ac | opnd_val; exp_sel = 32'd4; end
            4'd2:  begin lat = 6; nac = opnd_val; end
            4'd3:  lat = 4;
            4'd4:  nac = 32'd0;
            4'd10: nac = ~m_ac;
            4'd6:  npc = {5'd0, w[26:0]};
            4'd5: begin
                case (w[11:10])
                    2'b00:   take = $signed(m_ac) < 0;
                    2'b01:   take = (m_ac == 32'd0);
                    2'b10:   take = $signed(m_ac) > 0;
                    default: take = 1'b0;
                endcase
                if (take) npc = npc + 32'd2;
            end
            default: ;
        endcase
        obs  = 0;
        wcnt = 0;
        trace_pc.push_back(pc);
        trace_ac.push_back(ac);
        for (int c = 1; c <= 10; c++) begin
            if (noise) start = 1'($urandom_range(0, 1));
            chk("oe_we_exclusive", {31'd0, mem_oe & mem_we}, 32'd0);
            if (c == 1) begin
                chk("fetch_addr", 32'(mem_addr), 32'(m_pc[AW-1:0]));
                chk("fetch_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'b110);
                chk("pc", pc, m_pc);
                chk("ac", ac, m_ac);
                chk("not_halted", 32'(halted), 32'd0);
            end
            if (c == 3) chk("decode_cs", 32'(mem_cs), 32'd0);
            if (mem_we) begin
                wcnt++;
                chk("store_addr", 32'(mem_addr), 32'(opa));
                chk("store_data", mem_wdata, m_ac);
                st_q.push_back(mem_wdata);
                st_addr_q.push_back(32'(mem_addr));
            end
            if (is_alu && c == 6) begin
                chk("alu_sel", 32'(alu_sel), exp_sel);
                sel_q.push_back(32'(alu_sel));
            end
            if (done) obs = c;
            tick();
            if (obs != 0 || (op == 4'd1 && c == 3)) break;
        end
        chk("latency", obs, (op == 4'd1) ? 32'd0 : 32'(lat));
        chk("store_cycles", wcnt, (op == 4'd3) ? 32'd1 : 32'd0);
        lat_q.push_back(obs);
        if (op == 4'd3) mm[opa] = m_ac;
        m_pc   = npc;
        m_ac   = nac;
        m_halt = (op == 4'd1);
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            chk("halted", 32'(halted), 32'd1);
            chk("halt_pc", pc, m_pc);
            chk("halt_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
            tick();
        end
    endtask

    task automatic run_prog(input int budget, input bit noise, input bit need_halt);
        m_halt = 1'b0;
        for (int i = 0; i < budget && !m_halt; i++) step_instr(noise);
        start = 1'b0;
        if (need_halt) chk("reached_halt", 32'(m_halt), 32'd1);
        if (m_halt) check_halt(20);
    endtask

    initial begin
        logic [31:0] fib[$];
        logic [31:0] fib_exp [10];
        logic [3:0]  ops [12];
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        load_req    = 1'b0;
        fib_exp = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34, 32'd55};
        ops     = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};

        // Directed program: load/alu/store/skip/jump, ending in a self-planted HALT.
        clear_mem();
        mm['h100] = ins(4'd2, 27'h110);
        mm['h102] = ins(4'd0, 27'h112);
        mm['h104] = ins(4'd7, 27'h112);
        mm['h106] = ins(4'd2, 27'h116);
        mm['h108] = ins(4'd3, 27'h114);
        mm['h10A] = ins(4'd4, 27'h0);
        mm['h10C] = ins(4'd2, 27'h114);
        mm['h10E] = ins(4'd6, 27'h120);
        mm['h120] = ins(4'd4, 27'h0);
        mm['h122] = ins(4'd5, 27'(2'b01) << 10);
        mm['h124] = ins(4'd1, 27'h0);
        mm['h126] = ins(4'd5, 27'(2'b10) << 10);
        mm['h128] = ins(4'd10, 27'h0);
        mm['h12A] = ins(4'd5, 27'(2'b00) << 10);
        mm['h12C] = ins(4'd1, 27'h0);
        mm['h12E] = ins(4'd2, 27'h118);
        mm['h130] = ins(4'd3, 27'h100);
        mm['h132] = ins(4'd6, 27'h100);
        mm['h110] = 32'd5;
        mm['h112] = 32'd3;
        mm['h116] = 32'hDEADBEEF;
        mm['h118] = 32'h0800_0000;
        load_mem();
        do_reset();
        do_start();
        run_prog(40, 1'b0, 1'b1);
        chk("lit_load_ac", trace_ac[1], 32'd5);
        chk("lit_load_pc", trace_pc[1], 32'h102);
        chk("lit_load_lat", lat_q[0], 32'd6);
        chk("lit_add_ac", trace_ac[2], 32'd8);
        chk("lit_add_sel", sel_q[0], 32'd1);
        chk("lit_add_lat", lat_q[1], 32'd7);
        chk("lit_sub_ac", trace_ac[3], 32'd5);
        chk("lit_sub_sel", sel_q[1], 32'd2);
        chk("lit_store_data", st_q[0], 32'hDEADBEEF);
        chk("lit_store_addr", st_addr_q[0], 32'h114);
        chk("lit_store_lat", lat_q[4], 32'd4);
        chk("lit_clear_lat", lat_q[5], 32'd3);
        chk("lit_readback", trace_ac[7], 32'hDEADBEEF);
        chk("lit_jump_pc", trace_pc[8], 32'h120);
        chk("lit_skip_zero", trace_pc[10], 32'h126);
        chk("lit_skip_pos_no", trace_pc[11], 32'h128);
        chk("lit_skip_neg", trace_pc[13], 32'h12E);
        chk("lit_halt_pc", pc, 32'h102);

        // Fibonacci: b-values stored each iteration.
        clear_mem();
        mm['h100] = ins(4'd2, 27'h180);
        mm['h102] = ins(4'd0, 27'h181);
        mm['h104] = ins(4'd3, 27'h182);
        mm['h106] = ins(4'd2, 27'h181);
        mm['h108] = ins(4'd3, 27'h180);
        mm['h10A] = ins(4'd2, 27'h182);
        mm['h10C] = ins(4'd3, 27'h181);
        mm['h10E] = ins(4'd2, 27'h183);
        mm['h110] = ins(4'd0, 27'h184);
        mm['h112] = ins(4'd3, 27'h183);
        mm['h114] = ins(4'd5, 27'(2'b01) << 10);
        mm['h116] = ins(4'd6, 27'h100);
        mm['h118] = ins(4'd1, 27'h0);
        mm['h180] = 32'd1;
        mm['h181] = 32'd0;
        mm['h183] = 32'hFFFF_FFF6;
        mm['h184] = 32'd1;
        load_mem();
        do_reset();
        do_start();
        run_prog(200, 1'b0, 1'b1);
        foreach (st_q[i]) if (st_addr_q[i] == 32'h181) fib.push_back(st_q[i]);
        chk("fib_len", fib.size(), 32'd10);
        for (int i = 0; i < 10; i++) if (i < fib.size()) chk("fib_value", fib[i], fib_exp[i]);

        // Reset aborts: mid-STORE (no write) and mid-M_READ.
        clear_mem();
        mm['h100] = ins(4'd2, 27'h110);
        mm['h102] = ins(4'd3, 27'h114);
        mm['h104] = ins(4'd2, 27'h112);
        mm['h110] = 32'd5;
        mm['h112] = 32'd7;
        load_mem();
        do_reset();
        do_start();
        step_instr(1'b0);
        repeat (3) tick();
        chk("pre_abort_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
        tick();
        chk("abort_pc", pc, 32'h100);
        chk("abort_ac", ac, 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_no_write", ram[14'h114], 32'd0);
        do_reset();
        do_start();
        step_instr(1'b0);
        step_instr(1'b0);
        repeat (4) tick();
        chk("mread_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'b110);
        chk("mread_addr", 32'(mem_addr), 32'h112);
        reset = 1'b1;
        tick();
        chk("mread_rst_pc", pc, 32'h100);
        chk("mread_rst_ac", ac, 32'd0);
        do_reset();

        // Random programs with start noise while running.
        for (int r = 0; r < 3; r++) begin
            clear_mem();
            for (int a = 'h100; a < 'h200; a += 2) begin
                logic [3:0]  op;
                logic [26:0] arg;
                op = ops[$urandom_range(0, 11)];
                if (op == 4'd6) arg = 27'('h100 + 2 * $urandom_range(0, 127));
                else if (op == 4'd5) arg = 27'($urandom_range(0, 3)) << 10;
                else arg = 27'('h200 + $urandom_range(0, 63));
                mm[a] = {1'($urandom_range(0, 1)), op, arg};
            end
            for (int i = 0; i < 64; i++) mm['h200 + i] = $urandom;
            load_mem();
            do_reset();
            do_start();
            run_prog(150, 1'b1, 1'b0);
        end
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
